// File: rtl/cw_decoder_ctrl.sv
// Sequencer around decoder_top: loads NUM_WORDS codewords, pulses start, packs the
// serial decoded bits LSB-first into OUT_W-bit words and streams them out through a small FIFO.
module cw_decoder_ctrl #(
  parameter int CW_W       = 20,
  parameter int NUM_WORDS  = 8,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [CW_W-1:0]  in_data,
  output logic             in_ready,
  output logic             dec_wr_en,
  output logic [CW_W-1:0]  dec_msg_bype,
  output logic             dec_start,
  input  logic             dec_bin_msg,
  input  logic             dec_msg_rdy,
  input  logic             dec_msg_done,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_ovf,
  output logic [15:0]      blk_cnt
);

  localparam int WC_W  = $clog2(NUM_WORDS + 1);
  localparam int BC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [WC_W-1:0]    wcnt_r;
  logic [BC_W-1:0]    bitcnt_r;
  logic               full_r;
  logic [OUT_W-1:0]   pack_r;
  logic [TMO_W-1:0]   tmo_r;
  logic [OUT_W:0]     mem_r [FIFO_DEPTH];
  logic [PTR_W:0]     wptr_r, rptr_r;

  logic               xfer_s, tmo_hit_s, fifo_empty_s, fifo_full_s;
  logic               push_s, pop_s, do_push_s, ovf_s;
  logic [OUT_W:0]     push_data_s;

  assign xfer_s       = (state_r == S_LOAD) && in_valid;
  assign tmo_hit_s    = (state_r == S_RUN) && !dec_msg_rdy && !dec_msg_done &&
                        (tmo_r == TMO_W'(TIMEOUT - 1));
  assign fifo_empty_s = (wptr_r == rptr_r);
  assign fifo_full_s  = (wptr_r[PTR_W] != rptr_r[PTR_W]) &&
                        (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]);
  assign pop_s        = !fifo_empty_s && out_ready;
  assign do_push_s    = push_s && (!fifo_full_s || pop_s);
  assign ovf_s        = push_s && fifo_full_s && !pop_s;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = fifo_empty_s ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt_s = (xfer_s && wcnt_r == WC_W'(NUM_WORDS - 1)) ? S_START : S_LOAD;
      S_START: state_nxt_s = S_RUN;
      S_RUN: begin
        if (dec_msg_done)   state_nxt_s = S_FLUSH;
        else if (tmo_hit_s) state_nxt_s = S_IDLE;
        else                state_nxt_s = S_RUN;
      end
      S_FLUSH: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State-decoded outputs; codeword passthrough to the decoder is combinational
  always_comb begin
    in_ready     = 1'b0;
    dec_wr_en    = 1'b0;
    dec_msg_bype = {CW_W{1'b0}};
    dec_start    = 1'b0;
    busy         = 1'b1;
    case (state_r)
      S_IDLE:  busy = 1'b0;
      S_LOAD: begin
        in_ready     = 1'b1;
        dec_wr_en    = in_valid;
        dec_msg_bype = in_valid ? in_data : {CW_W{1'b0}};
      end
      S_START: dec_start = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // A full pack word waits until the next bit arrives (not last) or the block flushes (last)
  always_comb begin
    push_s      = 1'b0;
    push_data_s = {(OUT_W + 1){1'b0}};
    if (state_r == S_RUN && dec_msg_rdy && full_r) begin
      push_s      = 1'b1;
      push_data_s = {1'b0, pack_r};
    end else if (state_r == S_FLUSH && (bitcnt_r != BC_W'(0) || full_r)) begin
      push_s      = 1'b1;
      push_data_s = {1'b1, pack_r};
    end else begin
      push_s      = 1'b0;
    end
  end

  // Word, bit and timeout counters plus the pack register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wcnt_r   <= '0;
      bitcnt_r <= '0;
      full_r   <= 1'b0;
      pack_r   <= '0;
      tmo_r    <= '0;
    end else begin
      wcnt_r <= (state_r == S_LOAD) ? (xfer_s ? wcnt_r + WC_W'(1) : wcnt_r) : WC_W'(0);
      if (state_r != S_RUN || dec_msg_rdy || dec_msg_done) tmo_r <= '0;
      else                                                 tmo_r <= tmo_r + TMO_W'(1);
      if (state_r != S_RUN) begin
        bitcnt_r <= '0;
        full_r   <= 1'b0;
        pack_r   <= '0;
      end else if (dec_msg_rdy) begin
        if (full_r) begin
          pack_r   <= {{(OUT_W - 1){1'b0}}, dec_bin_msg};
          bitcnt_r <= BC_W'(1);
          full_r   <= 1'b0;
        end else begin
          pack_r[bitcnt_r] <= dec_bin_msg;
          if (bitcnt_r == BC_W'(OUT_W - 1)) begin
            bitcnt_r <= '0;
            full_r   <= 1'b1;
          end else begin
            bitcnt_r <= bitcnt_r + BC_W'(1);
          end
        end
      end
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r[PTR_W-1:0]] <= push_data_s;
        wptr_r <= wptr_r + (PTR_W + 1)'(1);
      end
      if (pop_s) rptr_r <= rptr_r + (PTR_W + 1)'(1);
    end
  end

  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_empty_s ? {OUT_W{1'b0}} : mem_r[rptr_r[PTR_W-1:0]][OUT_W-1:0];
  assign out_last  = fifo_empty_s ? 1'b0 : mem_r[rptr_r[PTR_W-1:0]][OUT_W];

  // Sticky error flags and completed-block counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      blk_cnt     <= 16'd0;
    end else begin
      if (tmo_hit_s)          err_timeout <= 1'b1;
      if (ovf_s)              err_ovf     <= 1'b1;
      if (state_r == S_FLUSH) blk_cnt     <= blk_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cw_decoder_ctrl.sv
// Randomized self-checking bench for cw_decoder_ctrl: a bit-list model of the packer
// predicts the output stream, which one compare process checks on every handshake.
module tb_cw_decoder_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = 20'd0;
  logic        in_ready, dec_wr_en, dec_start;
  logic [19:0] dec_msg_bype;
  logic        dec_bin_msg = 1'b0, dec_msg_rdy = 1'b0, dec_msg_done = 1'b0;
  logic        out_valid, out_last, out_ready;
  logic [7:0]  out_data;
  logic        busy, err_timeout, err_ovf;
  logic [15:0] blk_cnt;

  cw_decoder_ctrl dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_wr_en(dec_wr_en), .dec_msg_bype(dec_msg_bype), .dec_start(dec_start),
    .dec_bin_msg(dec_bin_msg), .dec_msg_rdy(dec_msg_rdy), .dec_msg_done(dec_msg_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err_timeout(err_timeout), .err_ovf(err_ovf), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  exp_q[$];
  logic [19:0] exp_cw[$];
  logic [19:0] load_words[8];
  bit          rnd_ready = 1'b0;
  bit          fixed_ready = 1'b1;
  int          exp_blk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Word idx of a block of n bits: bits taken LSB-first, unused positions zero
  function automatic logic [8:0] model_word(input logic [63:0] bits, input int n, input int idx);
    logic [7:0] d;
    d = 8'd0;
    for (int j = 0; j < 8; j++)
      if (idx * 8 + j < n) d[j] = bits[idx * 8 + j];
    return {((idx + 1) * 8 >= n), d};
  endfunction

  function automatic int model_nwords(input int n);
    return (n + 7) / 8;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? ($urandom_range(0, 7) != 0) : fixed_ready;
    end
  end

  // Output stream and decoder write port against the model queues
  always @(negedge clk) begin
    if (rst_b) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_word: unexpected word 0x%0h, none required", {out_last, out_data});
        end else begin
          check("out_word", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
      end
      if (dec_wr_en) begin
        if (exp_cw.size() == 0) begin
          n_checks++;
          $display("FAIL dec_wr: unexpected write 0x%0h, none required", dec_msg_bype);
        end else begin
          check("dec_msg_bype", {12'd0, dec_msg_bype}, {12'd0, exp_cw.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_block(input bit hold);
    int  got = 0;
    int  cyc = 0;
    bit  s = 1'b0;
    for (int i = 0; i < 8; i++) exp_cw.push_back(load_words[i]);
    while (got < 8 && cyc < 300) begin
      in_valid = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_data  = load_words[got];
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (got == 0) check("busy_in_load", {31'd0, busy}, 32'd1);
        got++;
      end
      tick();
      cyc++;
    end
    if (got < 8) fail_now("load_wait");
    in_valid = 1'b1;
    in_data  = 20'hFFFFF;
    cyc = 0;
    do begin
      @(negedge clk);
      s = dec_start;
      if (cyc == 0) check("in_ready_after_load", {31'd0, in_ready}, 32'd0);
      tick();
      cyc++;
    end while (!s && cyc < 4);
    check("start_seen", {31'd0, s}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("start_pulse_width", {31'd0, dec_start}, 32'd0);
    tick();
  endtask

  task automatic emit_bits(input logic [63:0] bits, input int n, input bit coincide, input int gapmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) tick();
      dec_msg_rdy  = 1'b1;
      dec_bin_msg  = bits[i];
      dec_msg_done = coincide && (i == n - 1);
      tick();
      dec_msg_rdy  = 1'b0;
      dec_msg_done = 1'b0;
      dec_bin_msg  = 1'b0;
    end
    if (!(coincide && n > 0)) begin
      repeat ($urandom_range(0, gapmax)) tick();
      dec_msg_done = 1'b1;
      tick();
      dec_msg_done = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      tick();
      cyc++;
    end
    if (exp_q.size() != 0) fail_now(name);
    repeat (2) tick();
  endtask

  task automatic run_block(input logic [63:0] bits, input int n, input bit coincide,
                           input int gapmax, input bit hold);
    for (int w = 0; w < model_nwords(n); w++) exp_q.push_back(model_word(bits, n, w));
    load_block(hold);
    emit_bits(bits, n, coincide, gapmax);
    exp_blk++;
    drain("drain_wait");
    check("blk_cnt", {16'd0, blk_cnt}, exp_blk[31:0] & 32'hFFFF);
  endtask

  initial begin
    logic [63:0] rb;
    int cnt;

    // model pinned against hand-computed words
    check("model_a5c_w0", {23'd0, model_word(64'hA5C, 12, 0)}, 32'h05C);
    check("model_a5c_w1", {23'd0, model_word(64'hA5C, 12, 1)}, 32'h10A);
    check("model_beef_w0", {23'd0, model_word(64'hBEEF, 16, 0)}, 32'h0EF);
    check("model_beef_w1", {23'd0, model_word(64'hBEEF, 16, 1)}, 32'h1BE);
    check("model_nwords16", model_nwords(16), 32'd2);
    check("model_nwords0", model_nwords(0), 32'd0);

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    check("rst_errs", {30'd0, err_timeout, err_ovf}, 32'd0);
    tick();
    rst_b = 1'b1;
    tick();

    load_words = '{20'd32938, 20'd93735, 20'd56609, 20'd11423,
                   20'd169931, 20'd216429, 20'd290567, 20'd146104};
    run_block(64'hA5C, 12, 1'b0, 2, 1'b1);
    run_block(64'hBEEF, 16, 1'b1, 1, 1'b1);

    rnd_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 8; i++) load_words[i] = 20'($urandom);
      rb = {$urandom, $urandom};
      run_block(rb, $urandom_range(0, 40), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1));
    end
    check("no_ovf_random", {31'd0, err_ovf}, 32'd0);
    check("no_tmo_random", {31'd0, err_timeout}, 32'd0);

    // overflow: 48 bits into a stalled FIFO keeps only the first four words
    rnd_ready = 1'b0;
    fixed_ready = 1'b0;
    rb = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) load_words[i] = 20'($urandom);
    for (int w = 0; w < 4; w++) exp_q.push_back(model_word(rb, 48, w));
    load_block(1'b0);
    emit_bits(rb, 48, 1'b0, 1);
    exp_blk++;
    in_valid = 1'b1;
    in_data  = 20'h12345;
    repeat (10) tick();
    check("ovf_flag", {31'd0, err_ovf}, 32'd1);
    check("ovf_blocks_next_load", {30'd0, busy, in_ready}, 32'd0);
    check("ovf_fifo_full_head", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    fixed_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_blk_cnt", {16'd0, blk_cnt}, exp_blk[31:0] & 32'hFFFF);
    check("ovf_drained", {31'd0, out_valid}, 32'd0);

    // timeout: the decoder never answers
    for (int i = 0; i < 8; i++) load_words[i] = 20'($urandom);
    load_block(1'b1);
    cnt = 2;
    while (cnt < 1200) begin
      @(negedge clk);
      if (!busy) break;
      tick();
      cnt++;
    end
    check("tmo_cycle", cnt, 32'd1025);
    check("tmo_flag", {31'd0, err_timeout}, 32'd1);
    check("tmo_blk_cnt", {16'd0, blk_cnt}, exp_blk[31:0] & 32'hFFFF);
    repeat (4) tick();
    check("tmo_no_words", {31'd0, out_valid}, 32'd0);

    // asynchronous reset in the middle of a load
    for (int i = 0; i < 3; i++) exp_cw.push_back(20'(32'h100 + i));
    cnt = 0;
    while (cnt < 3) begin
      in_valid = 1'b1;
      in_data  = 20'(32'h100 + cnt);
      @(negedge clk);
      if (in_ready) cnt++;
      tick();
    end
    in_data = 20'hABCDE;
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_wr_en", {31'd0, dec_wr_en}, 32'd0);
    check("arst_bype", {12'd0, dec_msg_bype}, 32'd0);
    check("arst_in_ready_busy", {30'd0, in_ready, busy}, 32'd0);
    check("arst_errs", {30'd0, err_timeout, err_ovf}, 32'd0);
    check("arst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    check("arst_out", {22'd0, out_valid, out_last, out_data}, 32'd0);
    in_valid = 1'b0;
    exp_cw.delete();
    exp_blk = 0;
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) load_words[i] = 20'($urandom);
    rb = {$urandom, $urandom};
    run_block(rb, 21, 1'b0, 2, 1'b1);
    check("post_rst_errs", {30'd0, err_timeout, err_ovf}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
